// File: rtl/operand_loader.sv
// Four-operand load sequencer: accepts x, dx, a, u over a valid/ready handshake and strobes each one.
// Optional zero-dx rejection is enabled by defining OPERAND_LOADER_DX_CHECK_EN.
module operand_loader #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] operand_data,
  output logic             s1,
  output logic             s2,
  output logic             s3,
  output logic             s4,
  output logic             ready,
  output logic [2:0]       loaded_cnt,
  output logic             error
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_X,
    LOAD_DX,
    LOAD_A,
    LOAD_U,
    READY
  } state_t;

  state_t state;
  logic   dx_reject;

  always_comb begin
    in_ready = (state == LOAD_X) || (state == LOAD_DX) ||
               (state == LOAD_A) || (state == LOAD_U);
  end

`ifdef OPERAND_LOADER_DX_CHECK_EN
  logic err_q;

  assign dx_reject = in_valid && !clear && (state == LOAD_DX) && (in_data == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= dx_reject;
  end

  assign error = err_q;
`else
  assign dx_reject = 1'b0;
  assign error     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      operand_data <= '0;
      s1           <= 1'b0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      s4           <= 1'b0;
      ready        <= 1'b0;
      loaded_cnt   <= '0;
    end else begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
      s4 <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            state      <= LOAD_X;
            loaded_cnt <= '0;
          end
        end
        LOAD_X, LOAD_DX, LOAD_A, LOAD_U: begin
          // Abort takes priority over a handshake in the same cycle.
          if (clear) begin
            state      <= IDLE;
            loaded_cnt <= '0;
          end else if (in_valid) begin
            operand_data <= in_data;
            if (dx_reject) begin
              state      <= LOAD_X;
              loaded_cnt <= '0;
            end else begin
              loaded_cnt <= loaded_cnt + 3'd1;
              case (state)
                LOAD_X:  begin state <= LOAD_DX; s1 <= 1'b1; end
                LOAD_DX: begin state <= LOAD_A;  s2 <= 1'b1; end
                LOAD_A:  begin state <= LOAD_U;  s3 <= 1'b1; end
                default: begin state <= READY;   s4 <= 1'b1; ready <= 1'b1; end
              endcase
            end
          end
        end
        READY: begin
          if (clear) begin
            state <= IDLE;
            ready <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader: basic load, stall, abort, ready hold, async reset, dx check.
module tb_operand_loader;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             go;
  logic             clear;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic [WIDTH-1:0] operand_data;
  logic             s1, s2, s3, s4;
  logic             ready;
  logic [2:0]       loaded_cnt;
  logic             error;
  logic [3:0]       strb;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] words [4] = '{16'h0003, 16'h0001, 16'h0005, 16'h0002};

  assign strb = {s1, s2, s3, s4};

  always #5 clk = ~clk;

  operand_loader #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .go           (go),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .operand_data (operand_data),
    .s1           (s1),
    .s2           (s2),
    .s3           (s3),
    .s4           (s4),
    .ready        (ready),
    .loaded_cnt   (loaded_cnt),
    .error        (error)
  );

  // Advance past one rising edge; outputs are then stable for checking.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; go = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) tick();
    total++;
    if ({operand_data, strb, ready, loaded_cnt, error, in_ready} !== '0) begin
      bad++;
      $display("FAIL reset_state: od=%h strb=%b ready=%b cnt=%0d err=%b in_ready=%b required all 0",
               operand_data, strb, ready, loaded_cnt, error, in_ready);
    end
    reset_n = 1'b1;
    tick();
    total++;
    if (in_ready !== 1'b0 || ready !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: in_ready=%b ready=%b required 0 0", in_ready, ready);
    end
  endtask

  task automatic test_basic();
    go = 1'b1;
    tick();
    go = 1'b0;
    total++;
    if (in_ready !== 1'b1 || loaded_cnt !== 3'd0) begin
      bad++;
      $display("FAIL go_to_load_x: in_ready=%b cnt=%0d required 1 0", in_ready, loaded_cnt);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = words[i];
      tick();
      total++;
      if (strb !== (4'b1000 >> i) || operand_data !== words[i] || loaded_cnt !== 3'(i + 1)) begin
        bad++;
        $display("FAIL basic_word%0d: strb=%b od=%h cnt=%0d required %b %h %0d",
                 i, strb, operand_data, loaded_cnt, 4'b1000 >> i, words[i], i + 1);
      end
    end
    in_valid = 1'b0;
    tick();
    total++;
    if (ready !== 1'b1 || loaded_cnt !== 3'd4 || strb !== 4'b0000 || in_ready !== 1'b0 ||
        operand_data !== 16'h0002) begin
      bad++;
      $display("FAIL basic_ready: ready=%b cnt=%0d strb=%b in_ready=%b od=%h required 1 4 0000 0 0002",
               ready, loaded_cnt, strb, in_ready, operand_data);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++;
    if (ready !== 1'b0) begin
      bad++;
      $display("FAIL basic_clear: ready=%b required 0", ready);
    end
  endtask

  task automatic test_stall();
    go = 1'b1;
    tick();
    go = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_data = words[i];
      tick();
    end
    in_valid = 1'b0;
    in_data  = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (strb !== 4'b0000 || loaded_cnt !== 3'd2 || operand_data !== 16'h0001 || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL stall_cycle%0d: strb=%b cnt=%0d od=%h in_ready=%b required 0000 2 0001 1",
                 i, strb, loaded_cnt, operand_data, in_ready);
      end
    end
    in_valid = 1'b1;
    in_data  = words[2];
    tick();
    total++;
    if (strb !== 4'b0010 || operand_data !== 16'h0005 || loaded_cnt !== 3'd3) begin
      bad++;
      $display("FAIL stall_s3: strb=%b od=%h cnt=%0d required 0010 0005 3", strb, operand_data, loaded_cnt);
    end
    in_data = words[3];
    tick();
    in_valid = 1'b0;
    total++;
    if (strb !== 4'b0001 || ready !== 1'b1 || loaded_cnt !== 3'd4) begin
      bad++;
      $display("FAIL stall_ready: strb=%b ready=%b cnt=%0d required 0001 1 4", strb, ready, loaded_cnt);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_abort();
    go = 1'b1;
    tick();
    go = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_data = words[i];
      tick();
    end
    in_data = words[2];
    clear   = 1'b1;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    total++;
    if (strb !== 4'b0000 || loaded_cnt !== 3'd0 || in_ready !== 1'b0 || operand_data !== 16'h0001) begin
      bad++;
      $display("FAIL abort_load_a: strb=%b cnt=%0d in_ready=%b od=%h required 0000 0 0 0001",
               strb, loaded_cnt, in_ready, operand_data);
    end
    // clear and go together in IDLE: go wins
    go    = 1'b1;
    clear = 1'b1;
    tick();
    go    = 1'b0;
    clear = 1'b0;
    total++;
    if (in_ready !== 1'b1 || loaded_cnt !== 3'd0) begin
      bad++;
      $display("FAIL abort_restart: in_ready=%b cnt=%0d required 1 0", in_ready, loaded_cnt);
    end
    in_valid = 1'b1;
    in_data  = words[0];
    tick();
    total++;
    if (strb !== 4'b1000 || operand_data !== 16'h0003) begin
      bad++;
      $display("FAIL abort_restart_s1: strb=%b od=%h required 1000 0003", strb, operand_data);
    end
    for (int i = 1; i < 4; i++) begin
      in_data = words[i];
      tick();
    end
    in_valid = 1'b0;
    total++;
    if (ready !== 1'b1 || loaded_cnt !== 3'd4) begin
      bad++;
      $display("FAIL abort_complete: ready=%b cnt=%0d required 1 4", ready, loaded_cnt);
    end
  endtask

  task automatic test_ready_hold();
    go = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (ready !== 1'b1 || loaded_cnt !== 3'd4 || in_ready !== 1'b0 || strb !== 4'b0000) begin
        bad++;
        $display("FAIL hold_cycle%0d: ready=%b cnt=%0d in_ready=%b strb=%b required 1 4 0 0000",
                 i, ready, loaded_cnt, in_ready, strb);
      end
    end
    go    = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++;
    if (ready !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL hold_clear: ready=%b in_ready=%b required 0 0", ready, in_ready);
    end
    go = 1'b1;
    tick();
    go = 1'b0;
    total++;
    if (in_ready !== 1'b1 || loaded_cnt !== 3'd0) begin
      bad++;
      $display("FAIL hold_go_after_idle: in_ready=%b cnt=%0d required 1 0", in_ready, loaded_cnt);
    end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1;
    in_data  = words[0];
    tick();
    in_valid = 1'b0;
    total++;
    if (s1 !== 1'b1 || operand_data !== 16'h0003 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_load_dx: s1=%b od=%h in_ready=%b required 1 0003 1", s1, operand_data, in_ready);
    end
    #1;
    reset_n = 1'b0;
    #1;
    total++;
    if ({operand_data, strb, ready, loaded_cnt, error, in_ready} !== '0) begin
      bad++;
      $display("FAIL async_reset: od=%h strb=%b ready=%b cnt=%0d err=%b in_ready=%b required all 0",
               operand_data, strb, ready, loaded_cnt, error, in_ready);
    end
    tick();
    #1;
    reset_n = 1'b1;
    tick();
    total++;
    if (in_ready !== 1'b0 || loaded_cnt !== 3'd0 || operand_data !== '0) begin
      bad++;
      $display("FAIL reset_discard: in_ready=%b cnt=%0d od=%h required 0 0 0000", in_ready, loaded_cnt, operand_data);
    end
  endtask

  task automatic test_dx_zero();
    go = 1'b1;
    tick();
    go = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h0003;
    tick();
    in_data = 16'h0000;
    tick();
`ifdef OPERAND_LOADER_DX_CHECK_EN
    total++;
    if (error !== 1'b1 || strb !== 4'b0000 || loaded_cnt !== 3'd0 || operand_data !== 16'h0000 ||
        in_ready !== 1'b1) begin
      bad++;
      $display("FAIL dx_reject: err=%b strb=%b cnt=%0d od=%h in_ready=%b required 1 0000 0 0000 1",
               error, strb, loaded_cnt, operand_data, in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      in_data = words[i];
      tick();
      total++;
      if (strb !== (4'b1000 >> i) || operand_data !== words[i] || error !== 1'b0) begin
        bad++;
        $display("FAIL dx_resend%0d: strb=%b od=%h err=%b required %b %h 0",
                 i, strb, operand_data, error, 4'b1000 >> i, words[i]);
      end
    end
`else
    total++;
    if (error !== 1'b0 || strb !== 4'b0100 || loaded_cnt !== 3'd2 || operand_data !== 16'h0000) begin
      bad++;
      $display("FAIL dx_zero_accept: err=%b strb=%b cnt=%0d od=%h required 0 0100 2 0000",
               error, strb, loaded_cnt, operand_data);
    end
    for (int i = 2; i < 4; i++) begin
      in_data = words[i];
      tick();
    end
`endif
    in_valid = 1'b0;
    tick();
    total++;
    if (ready !== 1'b1 || loaded_cnt !== 3'd4 || error !== 1'b0) begin
      bad++;
      $display("FAIL dx_complete: ready=%b cnt=%0d err=%b required 1 4 0", ready, loaded_cnt, error);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_abort();
    test_ready_hold();
    test_async_reset();
    test_dx_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand word width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port go, input, 1 bit: requests a new four-operand load sequence.
REQ-005 The block SHALL have port clear, input, 1 bit: consumer acknowledge and abort.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the upstream word is valid.
REQ-007 The block SHALL have port in_data, input, WIDTH bits: the upstream operand word.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-009 The block SHALL have port operand_data, output, WIDTH bits: the last accepted word.
REQ-010 The block SHALL have ports s1, s2, s3, s4, outputs, 1 bit each: one-cycle strobes for x, dx, a and u respectively.
REQ-011 The block SHALL have port ready, output, 1 bit: all four operands have been delivered.
REQ-012 The block SHALL have port loaded_cnt, output, 3 bits: the number of operands accepted in the current sequence, range 0-4.
REQ-013 The block SHALL have port error, output, 1 bit: a one-cycle rejection pulse (see REQ-026).

Function
REQ-014 The state machine SHALL have the states IDLE, LOAD_X, LOAD_DX, LOAD_A, LOAD_U and READY.
REQ-015 IDLE: go=1 -> LOAD_X, with loaded_cnt cleared to 0; go is ignored in every other state.
REQ-016 in_ready SHALL be 1 exactly in LOAD_X, LOAD_DX, LOAD_A and LOAD_U, and SHALL be driven combinationally from state.
REQ-017 A handshake (in_valid & in_ready) SHALL register in_data into operand_data, increment loaded_cnt and advance the state: LOAD_X -> LOAD_DX -> LOAD_A -> LOAD_U -> READY.
REQ-018 The strobe for the accepted word (s1 for x, s2 for dx, s3 for a, s4 for u) SHALL be 1 for exactly the cycle after the handshake, when operand_data already holds that word.
REQ-019 At most one of s1..s4 SHALL be 1 in any cycle, and all SHALL be 0 when no handshake occurred in the previous cycle.
REQ-020 operand_data SHALL hold its value between handshakes.
REQ-021 When in_valid=0 in a LOAD state, the block SHALL stall indefinitely with no strobe and no change to loaded_cnt.
REQ-022 READY: ready=1 and loaded_cnt=4; clear=1 -> IDLE, with ready falling in the following cycle; the block SHALL remain in READY otherwise.
REQ-023 If clear=1 in any LOAD state, the block SHALL abort to IDLE with loaded_cnt=0; a handshake in that same cycle SHALL be discarded, with no capture and no strobe.
REQ-024 If clear=1 and go=1 in the same cycle in IDLE, go SHALL win and the block SHALL enter LOAD_X.

Reset
REQ-025 While reset_n=0, the block SHALL immediately force state=IDLE, operand_data=0, s1..s4=0, ready=0, loaded_cnt=0 and error=0, regardless of clk; when reset_n is asserted mid-sequence, the partial sequence SHALL be discarded.

Configuration
REQ-026 With macro OPERAND_LOADER_DX_CHECK_EN defined, a zero word accepted in LOAD_DX SHALL be rejected: no s2 strobe, error=1 for the next cycle, return to LOAD_X with loaded_cnt=0, and operand_data updated to 0.
REQ-027 Without OPERAND_LOADER_DX_CHECK_EN, a zero dx SHALL be handled like any other word, and error SHALL be tied to 0.

Verification
REQ-028 Reset, then go, then back-to-back words 0x0003, 0x0001, 0x0005, 0x0002 -> s1, s2, s3, s4 in four consecutive cycles with operand_data matching, then ready=1 and loaded_cnt=4.
REQ-029 Same words with in_valid deasserted for 3 cycles after the second word -> no strobes during the stall, s3 one cycle after the third handshake, and final ready=1.
REQ-030 clear=1 while in LOAD_A with in_valid=1 -> IDLE, loaded_cnt=0, no s3, and a following go restarts at LOAD_X.
REQ-031 Sequence complete, clear held 0 for 10 cycles -> ready stays 1; then clear=1 -> ready=0 one cycle later, and go ignored until IDLE.
REQ-032 reset_n pulsed low mid-cycle while in LOAD_DX -> all outputs 0 immediately, without waiting for a clock edge.
REQ-033 With OPERAND_LOADER_DX_CHECK_EN, words 0x0003, 0x0000 -> error pulse, no s2, and loaded_cnt=0; resending 0x0003, 0x0001, 0x0005, 0x0002 -> normal completion.
